// File: rtl/priority_decoder_seq.sv
// Queues 3-bit codes in a 4-entry FIFO and plays each one out as a one-hot y for HOLD
// cycles, followed by a one-cycle gap. Define DEC_ACT_LOW_EN to make y active-low.
module priority_decoder_seq #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] xin,
  input  logic       v,
  output logic       rdy,
  output logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [2:0] cnt
);

`ifdef DEC_ACT_LOW_EN
  localparam logic [7:0] Y_IDLE = 8'hFF;
`else
  localparam logic [7:0] Y_IDLE = 8'h00;
`endif
  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);
  localparam logic [2:0] FULL    = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t     state_q;
  logic [2:0] mem_q [4];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] hold_q;
  logic [7:0] y_q;
  logic       done_q;
  logic       busy_q;
  logic [2:0] code_q;
  logic [2:0] head;
  logic       push, pop;

  function automatic logic [7:0] drive_pattern(input logic [2:0] c);
    logic [7:0] onehot;
    onehot = 8'd1 << c;
    return Y_IDLE ^ onehot;
  endfunction

  assign rdy  = (cnt_q != FULL);
  assign push = v && rdy;
  assign pop  = ((state_q == IDLE) || (state_q == GAP)) && (cnt_q != 3'd0);
  assign head = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 2'd1;
    if (pop)  rptr_d = rptr_q + 2'd1;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (pop && !push) cnt_d = cnt_q - 3'd1;
  end

  // Storage carries no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= xin;
    if (pop)  code_q <= head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= Y_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (pop) begin
            state_q <= DRIVE;
            y_q     <= drive_pattern(head);
            hold_q  <= HOLD_M1;
            done_q  <= (HOLD == 1);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            y_q     <= Y_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        DRIVE: begin
          // hold_q counts the DRIVE cycles still to come; done is raised one edge early
          // so that it lines up with the final cycle as a registered pulse.
          if (hold_q == 4'd0) begin
            state_q <= GAP;
            y_q     <= Y_IDLE;
            done_q  <= 1'b0;
          end else begin
            hold_q  <= hold_q - 4'd1;
            done_q  <= (hold_q == 4'd1);
          end
        end
        default: begin
          state_q <= IDLE;
          y_q     <= Y_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq: directed scenarios plus random traffic, scored against
// a transaction-timing model (each accepted code gets a start edge from plain arithmetic).
module tb_priority_decoder_seq;
  localparam int HOLD = 4;
`ifdef DEC_ACT_LOW_EN
  localparam logic [7:0] YOFF = 8'hFF;
`else
  localparam logic [7:0] YOFF = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v;
  logic [2:0] xin;
  logic       rdy, busy, done;
  logic [7:0] y;
  logic [2:0] cnt;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  int acc_t[$];
  int st_t[$];
  logic [2:0] codes[$];

  always #5 clk = ~clk;

  priority_decoder_seq #(.HOLD(HOLD), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .xin(xin), .v(v),
    .rdy(rdy), .y(y), .busy(busy), .done(done), .cnt(cnt)
  );

  function automatic int m_cnt();
    int c = 0;
    foreach (acc_t[i]) if (acc_t[i] <= e) c++;
    foreach (st_t[i])  if (st_t[i] <= e) c--;
    return c;
  endfunction

  function automatic logic [7:0] m_y();
    logic [7:0] r = YOFF;
    logic [7:0] oh;
    foreach (st_t[i]) if (st_t[i] <= e && e < st_t[i] + HOLD) begin
      oh = 8'd1 << codes[i];
      r = YOFF ^ oh;
    end
    return r;
  endfunction

  function automatic logic m_done();
    logic r = 1'b0;
    foreach (st_t[i]) if (e == st_t[i] + HOLD - 1) r = 1'b1;
    return r;
  endfunction

  function automatic logic m_busy();
    logic r = 1'b0;
    foreach (st_t[i]) if (st_t[i] <= e && e <= st_t[i] + HOLD) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, expv, e);
    end
  endtask

  task automatic step(input logic vv, input logic [2:0] code, output logic accepted);
    logic mrdy;
    int s;
    v = vv;
    xin = code;
    mrdy = (m_cnt() != 4);
    chk("rdy", {31'b0, rdy}, {31'b0, mrdy});
    accepted = vv && mrdy;
    @(posedge clk);
    e++;
    if (accepted) begin
      s = e + 1;
      if (st_t.size() > 0 && st_t[$] + HOLD + 1 > s) s = st_t[$] + HOLD + 1;
      acc_t.push_back(e);
      st_t.push_back(s);
      codes.push_back(code);
    end
    #1;
    chk("y", {24'b0, y}, {24'b0, m_y()});
    chk("done", {31'b0, done}, {31'b0, m_done()});
    chk("busy", {31'b0, busy}, {31'b0, m_busy()});
    chk("cnt", {29'b0, cnt}, m_cnt());
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 3'bxxx, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_y"}, {24'b0, y}, {24'b0, YOFF});
    chk({tag, "_cnt"}, {29'b0, cnt}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
  endtask

  initial begin
    logic a;
    logic saw_full;
    int peak;
    int tries;
    logic [2:0] six[6];

    rst = 1'b0;
    v = 1'b0;
    xin = 3'd0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por_held");
    @(negedge clk);
    rst = 1'b0;

    // Single code 5: y=0x20 for HOLD cycles, done on the last, then gap and idle.
    step(1'b1, 3'd5, a);
    chk("single_accept", {31'b0, a}, 32'd1);
    idle(HOLD + 4);

    // Invalid cycles with undriven code must change nothing.
    idle(10);

    // Back-to-back 7,0,3.
    peak = 0;
    step(1'b1, 3'd7, a); if (cnt > peak) peak = cnt;
    step(1'b1, 3'd0, a); if (cnt > peak) peak = cnt;
    step(1'b1, 3'd3, a); if (cnt > peak) peak = cnt;
    for (int i = 0; i < 3 * (HOLD + 1) + 2; i++) begin
      step(1'b0, 3'bxxx, a);
      if (cnt > peak) peak = cnt;
    end
    chk("b2b_cnt_peak", peak, 32'd2);

    // Six codes with v held high: backpressure, then no loss or duplication.
    six[0] = 3'd1; six[1] = 3'd6; six[2] = 3'd2;
    six[3] = 3'd4; six[4] = 3'd7; six[5] = 3'd0;
    saw_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tries = 0;
      a = 1'b0;
      while (!a && tries < 40) begin
        if (rdy === 1'b0) saw_full = 1'b1;
        step(1'b1, six[k], a);
        tries++;
      end
      chk("six_accept", {31'b0, a}, 32'd1);
    end
    chk("six_rdy_dropped", {31'b0, saw_full}, 32'd1);
    idle(6 * (HOLD + 1) + 4);

    // Reset mid-DRIVE with three codes queued.
    step(1'b1, 3'd2, a);
    step(1'b1, 3'd3, a);
    step(1'b1, 3'd4, a);
    step(1'b1, 3'd5, a);
    chk("pre_rst_cnt", {29'b0, cnt}, 32'd3);
    rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    acc_t.delete();
    st_t.delete();
    codes.delete();
    @(posedge clk);
    e++;
    #1 check_reset_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'd6, a);
    chk("post_rst_accept", {31'b0, a}, 32'd1);
    idle(HOLD + 6);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) step(1'b1, 3'($urandom_range(0, 7)), a);
      else step(1'b0, 3'bxxx, a);
    end
    idle(5 * (HOLD + 1) + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
